pos_track_rx: RTL and testbench

Receive-side position tracker for the snake-scan direction stream. It consumes the 2-bit step codes emitted by the scan generator through a valid/ready handshake and integrates them into absolute (x, y) coordinates. It emits one position token per pixel, checks each step against the snake rules for the programmed frame size, and flags the last pixel of the frame. It sits on the consumer side of the scan path, feeding window/descriptor logic that needs explicit coordinates.

---
 rtl/pos_track_pkg.sv | 7 +
 rtl/pos_out_reg.sv | 24 ++
 rtl/pos_track_rx.sv | 98 +++++++++
 tb/tb_pos_track_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pos_track_pkg.sv
// pos_track_pkg: shared state encoding and step-code constants for the snake-scan position tracker.
package pos_track_pkg;
   typedef enum logic [1:0] {IDLE, TRACK, DONE, ERROR} state_t;
   localparam logic [1:0] DIR_RIGHT = 2'b00;
   localparam logic [1:0] DIR_LEFT = 2'b01;
   localparam int DIR_DOWN_BIT = 1;
endpackage

// File: rtl/pos_out_reg.sv
// pos_out_reg: one-entry valid/ready output register; a load overrides any pending or departing entry.
module pos_out_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] din,
   output logic         valid,
   input  logic         ready,
   output logic [W-1:0] dout
);
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         valid <= 1'b0;
         dout <= '0;
      end else if (load) begin
         valid <= 1'b1;
         dout <= din;
      end else if (clr || ready) begin
         valid <= 1'b0;
      end
endmodule

// File: rtl/pos_track_rx.sv
// pos_track_rx: integrates snake-scan step codes into (x, y) tokens, checks legality and marks the frame's last pixel.
module pos_track_rx
   import pos_track_pkg::*;
#(
   parameter int X_MAX = 5,
   parameter int Y_MAX = 5,
   localparam int XW = $clog2(X_MAX),
   localparam int YW = $clog2(Y_MAX)
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic            start,
   input  logic [XW-1:0]   max_x,
   input  logic [YW-1:0]   max_y,
   input  logic            step_valid,
   input  logic [1:0]      step_dir,
   output logic            step_ready,
   output logic            pos_valid,
   input  logic            pos_ready,
   output logic [XW-1:0]   pos_x,
   output logic [YW-1:0]   pos_y,
   output logic            pos_last,
   output logic [XW+YW-1:0] pix_cnt,
   output logic            busy,
   output logic            err
);
   localparam int W = 1 + 2 * (XW + YW);
   state_t state, state_n;
   logic [XW-1:0] mx, x, mxm1, nx, fx, fxm1, tx;
   logic [YW-1:0] my, y, mym1, ny, fy, fym1, ty;
   logic [XW+YW-1:0] cnt, tc;
   logic [W-1:0] tok;
   logic p, is_down, is_left, acc, legal, last, load, clr;
   always_comb begin
      is_down = step_dir[DIR_DOWN_BIT];
      is_left = step_dir == DIR_LEFT;
      p = y[0];
      mxm1 = mx - 1'b1;
      mym1 = my - 1'b1;
      step_ready = state == TRACK && !start && (!pos_valid || pos_ready);
      acc = step_valid && step_ready;
      legal = is_down ? (y < mym1 && x == (p ? '0 : mxm1)) :
              is_left ? (p && x != '0) : (step_dir == DIR_RIGHT && !p && x < mxm1);
      nx = is_down ? x : is_left ? x - 1'b1 : x + 1'b1;
      ny = is_down ? y + 1'b1 : y;
      // start evaluates the origin token against the incoming frame size, not the latched one
      fx = start ? max_x : mx;
      fy = start ? max_y : my;
      fxm1 = fx - 1'b1;
      fym1 = fy - 1'b1;
      tx = start ? '0 : nx;
      ty = start ? '0 : ny;
      tc = start ? '0 : cnt + 1'b1;
      last = ty == fym1 && tx == (fy[0] ? fxm1 : '0);
      load = start ? (fx != '0 && fy != '0) : acc && legal;
      clr = start && !load;
      state_n = state;
      if (start) state_n = !load ? ERROR : last ? DONE : TRACK;
      else if (state == TRACK && acc) state_n = !legal ? ERROR : last ? DONE : TRACK;
      else if (state == DONE && pos_valid && pos_ready) state_n = IDLE;
   end
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         mx <= '0;
         my <= '0;
         x <= '0;
         y <= '0;
         cnt <= '0;
         err <= 1'b0;
      end else begin
         if (start) begin
            mx <= max_x;
            my <= max_y;
         end
         if (load) begin
            x <= tx;
            y <= ty;
            cnt <= tc;
         end
         if (start) err <= clr;
         else if (acc && !legal) err <= 1'b1;
      end
   assign busy = state != IDLE;
   assign {pos_last, pix_cnt, pos_y, pos_x} = tok;
   pos_out_reg #(.W(W)) u_out (
      .clk  (clk),
      .n_rst(n_rst),
      .clr  (clr),
      .load (load),
      .din  ({last, tc, ty, tx}),
      .valid(pos_valid),
      .ready(pos_ready),
      .dout (tok)
   );
endmodule

// File: tb/tb_pos_track_rx.sv
// tb_pos_track_rx: table-driven step frames with a token scoreboard, plus hand-written abort/error/stall sequences.
module tb_pos_track_rx;
   localparam int XW = 3;
   localparam int YW = 3;
   typedef struct packed {
      logic [1:0] dir;
      logic [2:0] x;
      logic [2:0] y;
      logic       last;
      logic       ok;
   } vec_t;
   typedef logic [12:0] tok_t;
   logic clk = 1'b0, n_rst = 1'b0, start = 1'b0, step_valid = 1'b0, pos_ready = 1'b0;
   logic [XW-1:0] max_x = '0;
   logic [YW-1:0] max_y = '0;
   logic [1:0] step_dir = '0;
   logic step_ready, pos_valid, pos_last, busy, err;
   logic [XW-1:0] pos_x;
   logic [YW-1:0] pos_y;
   logic [XW+YW-1:0] pix_cnt;
   tok_t sb[$];
   vec_t t3[8];
   vec_t t42[7];
   int checks = 0, errors = 0, rdy_mode = 0, cnt_exp = 0;

   pos_track_rx #(.X_MAX(5), .Y_MAX(5)) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .max_x(max_x), .max_y(max_y),
      .step_valid(step_valid), .step_dir(step_dir), .step_ready(step_ready),
      .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_x(pos_x), .pos_y(pos_y),
      .pos_last(pos_last), .pix_cnt(pix_cnt), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // 0: always ready, 1: toggle each cycle, 2: stalled
   always @(posedge clk) begin
      #2;
      pos_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~pos_ready : 1'b0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk)
      if (n_rst && !start && pos_valid) begin
         if (sb.size() == 0) chk("spurious_token", pos_valid, 0);
         else begin
            chk("token", {pos_last, pix_cnt, pos_y, pos_x}, sb[0]);
            if (pos_ready) void'(sb.pop_front());
         end
         if (!pos_ready) chk("stall_step_ready", step_ready, 0);
      end

   task automatic do_start(input logic [2:0] mx, input logic [2:0] my, input logic sv, input logic [1:0] dir);
      start = 1'b1;
      max_x = mx;
      max_y = my;
      step_valid = sv;
      step_dir = dir;
      sb.delete();
      if (mx != 0 && my != 0) sb.push_back({(mx == 1 && my == 1), 6'd0, 3'd0, 3'd0});
      cnt_exp = 1;
      @(posedge clk);
      #1;
      start = 1'b0;
      step_valid = 1'b0;
   endtask

   task automatic send_step(input vec_t v, input logic tput);
      int w = 0;
      logic acc = 1'b0;
      step_valid = 1'b1;
      step_dir = v.dir;
      while (!acc && w < 40) begin
         @(negedge clk);
         if (step_ready) acc = 1'b1;
         else w++;
      end
      if (acc && v.ok) begin
         sb.push_back({v.last, 6'(cnt_exp), v.y, v.x});
         cnt_exp++;
      end
      chk("step_accept", acc, 1);
      if (tput) chk("throughput", w, 0);
      @(posedge clk);
      #1;
      step_valid = 1'b0;
   endtask

   task automatic drain(input logic exp_busy);
      int w = 0;
      do begin
         @(negedge clk);
         w++;
      end while ((sb.size() != 0 || pos_valid) && w < 60);
      chk("drain", int'(sb.size()) + int'(pos_valid), 0);
      @(posedge clk);
      #1;
      chk("busy_after", busy, exp_busy);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      t3 = '{'{2'b00, 3'd1, 3'd0, 1'b0, 1'b1}, '{2'b00, 3'd2, 3'd0, 1'b0, 1'b1},
             '{2'b10, 3'd2, 3'd1, 1'b0, 1'b1}, '{2'b01, 3'd1, 3'd1, 1'b0, 1'b1},
             '{2'b01, 3'd0, 3'd1, 1'b0, 1'b1}, '{2'b10, 3'd0, 3'd2, 1'b0, 1'b1},
             '{2'b00, 3'd1, 3'd2, 1'b0, 1'b1}, '{2'b00, 3'd2, 3'd2, 1'b1, 1'b1}};
      t42 = '{'{2'b00, 3'd1, 3'd0, 1'b0, 1'b1}, '{2'b00, 3'd2, 3'd0, 1'b0, 1'b1},
              '{2'b00, 3'd3, 3'd0, 1'b0, 1'b1}, '{2'b11, 3'd3, 3'd1, 1'b0, 1'b1},
              '{2'b01, 3'd2, 3'd1, 1'b0, 1'b1}, '{2'b01, 3'd1, 3'd1, 1'b0, 1'b1},
              '{2'b01, 3'd0, 3'd1, 1'b1, 1'b1}};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pos_valid", pos_valid, 0);
      chk("rst_step_ready", step_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_pix_cnt", pix_cnt, 0);
      chk("rst_pos", {pos_last, pos_y, pos_x}, 0);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_busy", busy, 0);

      do_start(3'd3, 3'd3, 1'b0, 2'b00);
      foreach (t3[i]) send_step(t3[i], 1'b1);
      drain(1'b0);

      do_start(3'd4, 3'd2, 1'b0, 2'b00);
      foreach (t42[i]) send_step(t42[i], 1'b1);
      drain(1'b0);

      rdy_mode = 1;
      do_start(3'd3, 3'd3, 1'b0, 2'b00);
      foreach (t3[i]) send_step(t3[i], 1'b0);
      drain(1'b0);
      rdy_mode = 0;

      do_start(3'd3, 3'd3, 1'b0, 2'b00);
      send_step('{2'b10, 3'd0, 3'd0, 1'b0, 1'b0}, 1'b1);
      chk("illegal_err", err, 1);
      chk("illegal_step_ready", step_ready, 0);
      chk("illegal_busy", busy, 1);
      chk("illegal_no_token", pos_valid, 0);
      step_valid = 1'b1;
      step_dir = 2'b00;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("error_step_ready", step_ready, 0);
         chk("error_sticky", err, 1);
      end
      step_valid = 1'b0;
      do_start(3'd3, 3'd3, 1'b0, 2'b00);
      chk("err_cleared", err, 0);
      drain(1'b1);

      do_start(3'd3, 3'd3, 1'b0, 2'b00);
      for (int i = 0; i < 4; i++) send_step(t3[i], 1'b1);
      rdy_mode = 2;
      do_start(3'd3, 3'd3, 1'b1, 2'b01);
      rdy_mode = 0;
      chk("abort_err", err, 0);
      drain(1'b1);

      do_start(3'd0, 3'd3, 1'b0, 2'b00);
      chk("zero_err", err, 1);
      chk("zero_busy", busy, 1);
      chk("zero_no_token", pos_valid, 0);
      step_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("zero_step_ready", step_ready, 0);
      chk("zero_no_token2", pos_valid, 0);
      step_valid = 1'b0;

      rdy_mode = 2;
      do_start(3'd1, 3'd1, 1'b0, 2'b00);
      chk("one_err", err, 0);
      step_valid = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("done_step_ready", step_ready, 0);
         chk("done_no_err", err, 0);
         chk("done_busy", busy, 1);
         chk("done_held", pos_valid, 1);
      end
      step_valid = 1'b0;
      rdy_mode = 0;
      drain(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
